sub_layer_seq: RTL and testbench
================================

SUB_LAYER_SEQ -- requirements
Module: sub_layer_seq

Interface
REQ-001 SHALL have parameter NB_SBOX, default 1, meaning S-box columns processed per cycle; legal values 1, 2, 4, 8, 16, 32, 64.
REQ-002 SHALL have port clock_i, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port resetb_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start_i, input, 1 bit: request to substitute state_i.
REQ-005 SHALL have port state_i, input, 320 bits: x0 = [319:256], x1 = [255:192], x2 = [191:128], x3 = [127:64], x4 = [63:0].
REQ-006 SHALL have port round_i, input, 4 bits: round index; present only when ADD_CONST_EN is defined.
REQ-007 SHALL have port state_o, output, 320 bits: working state register, same layout as state_i.
REQ-008 SHALL have port busy_o, output, 1 bit: high while in state RUN.
REQ-009 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.

Function
REQ-010 SHALL define column j (0..63) as the 5-bit word {x0[j], x1[j], x2[j], x3[j], x4[j]}, with x0[j] as the MSB.
REQ-011 SHALL instantiate NB_SBOX copies of the team's 5-bit sbox module and write each result back to the same column, in the same bit order.
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE or DONE with start_i=1, load state_i into the register on the clock edge, clear the column counter, and go to RUN.
REQ-014 SHALL, in RUN, on each edge substitute columns cnt*NB_SBOX to cnt*NB_SBOX+NB_SBOX-1 and increment cnt.
REQ-015 SHALL go from RUN to DONE on the edge that processes the final group, i.e. when cnt = 64/NB_SBOX-1.
REQ-016 SHALL go from DONE to IDLE on the next edge when start_i=0.
REQ-017 SHALL decode done_o from state DONE, so it is high for exactly one cycle per operation unless a back-to-back start occurs.
REQ-018 SHALL give a latency of 64/NB_SBOX edges: done_o rises on the (64/NB_SBOX)th rising edge after the edge that sampled start_i.
REQ-019 SHALL ignore start_i while in RUN: no reload, no counter change.
REQ-020 SHALL accept start_i while in DONE: that cycle still shows done_o=1, and the next edge enters RUN with the new state.
REQ-021 SHALL drive state_o from the register at all times; state_o is valid when done_o=1 and SHALL hold stable in IDLE until the next accepted start.
REQ-022 SHALL hold the register and counter in IDLE; the counter SHALL be ceil(log2(64/NB_SBOX)) bits, minimum 1 bit, and wrap to 0 on each new start.

Reset
REQ-023 SHALL, when resetb_i=0, asynchronously force FSM=IDLE, counter=0, state register=0, busy_o=0, done_o=0 and state_o=0.
REQ-024 SHALL, when reset is asserted mid-RUN, abort the operation with no done_o pulse; after release the block SHALL wait in IDLE for a fresh start_i.

Configuration
REQ-025 SHALL use the macro SUB_LAYER_ADD_CONST_EN to compile the Ascon constant-addition stage in or out.
REQ-026 SHALL, when SUB_LAYER_ADD_CONST_EN is defined, sample round_i with start_i and XOR the constant {4'hF - round_i, round_i} into x2[7:0] of state_i at load time, before any substitution.
REQ-027 SHALL, when SUB_LAYER_ADD_CONST_EN is not defined, omit the round_i port and load state_i unmodified.
REQ-028 SHALL have identical latency and handshake with or without SUB_LAYER_ADD_CONST_EN.

Verification
REQ-029 SHALL cover, without the macro and with NB_SBOX=1: state_i all zeros, pulse start -> done_o on the 64th edge; state_o x0=x1=x3=x4=0, x2=FFFFFFFFFFFFFFFF.
REQ-030 SHALL cover, with NB_SBOX=8: state_i all ones -> done_o on the 8th edge; state_o x0=x2=x3=x4=FFFFFFFFFFFFFFFF, x1=0.
REQ-031 SHALL cover, with the macro defined: state_i all zeros, round_i=0 -> x0=x1=x3=00000000000000F0, x2=FFFFFFFFFFFFFF0F, x4=0.
REQ-032 SHALL cover: start_i pulsed again at cycle 10 of RUN with a different state_i -> ignored, and the result matches the first operand only.
REQ-033 SHALL cover: resetb_i low for 1 cycle at cycle 20 of RUN -> all outputs 0 immediately, no done_o; a subsequent start completes normally.
REQ-034 SHALL cover: start_i held high through DONE -> done_o=1 for one cycle, busy_o=1 on the next cycle, and a second result 64/NB_SBOX edges later.

Source files
------------

// File: rtl/sub_layer_seq.sv
// Sequential Ascon substitution layer, NB_SBOX columns per clock.
// Define SUB_LAYER_ADD_CONST_EN to fold the round constant in at load.

module sub_layer_sbox (
  input  logic [4:0] x,
  output logic [4:0] y
);

  logic a0, a1, a2, a3, a4;
  logic t0, t1, t2, t3, t4;
  logic b0, b1, b2, b3, b4;

  // bit-sliced Ascon S-box, x[4] carries the x0 lane
  assign a0 = x[4] ^ x[0];
  assign a1 = x[3];
  assign a2 = x[2] ^ x[3];
  assign a3 = x[1];
  assign a4 = x[0] ^ x[1];

  assign t0 = ~a0 & a1;
  assign t1 = ~a1 & a2;
  assign t2 = ~a2 & a3;
  assign t3 = ~a3 & a4;
  assign t4 = ~a4 & a0;

  assign b0 = a0 ^ t1;
  assign b1 = a1 ^ t2;
  assign b2 = a2 ^ t3;
  assign b3 = a3 ^ t4;
  assign b4 = a4 ^ t0;

  assign y[4] = b0 ^ b4;
  assign y[3] = b1 ^ b0;
  assign y[2] = ~b2;
  assign y[1] = b3 ^ b2;
  assign y[0] = b4;

endmodule

module sub_layer_seq #(
  parameter int NB_SBOX = 1
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [319:0] state_i,
`ifdef SUB_LAYER_ADD_CONST_EN
  input  logic [3:0]   round_i,
`endif
  output logic [319:0] state_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int NGRP = 64 / NB_SBOX;
  localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [CW-1:0] LAST = CW'(NGRP - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  fsm_t          fsm_q, fsm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [319:0]  st_q, st_d;
  logic [319:0]  st_sub, st_ld;
  logic [5:0]    base;
  logic [63:0]   xs [5];
  logic [63:0]   nx [5];
  logic [4:0]    sb_in  [NB_SBOX];
  logic [4:0]    sb_out [NB_SBOX];

  assign xs[0] = st_q[319:256];
  assign xs[1] = st_q[255:192];
  assign xs[2] = st_q[191:128];
  assign xs[3] = st_q[127:64];
  assign xs[4] = st_q[63:0];

  assign base = 6'(int'(cnt_q) * NB_SBOX);

  always_comb begin
    for (int k = 0; k < NB_SBOX; k++) begin
      sb_in[k] = {xs[0][base + 6'(k)],
                  xs[1][base + 6'(k)],
                  xs[2][base + 6'(k)],
                  xs[3][base + 6'(k)],
                  xs[4][base + 6'(k)]};
    end
  end

  for (genvar g = 0; g < NB_SBOX; g++) begin : g_sbox
    sub_layer_sbox u_sbox (
      .x (sb_in[g]),
      .y (sb_out[g])
    );
  end

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      nx[i] = xs[i];
    end
    for (int k = 0; k < NB_SBOX; k++) begin
      nx[0][base + 6'(k)] = sb_out[k][4];
      nx[1][base + 6'(k)] = sb_out[k][3];
      nx[2][base + 6'(k)] = sb_out[k][2];
      nx[3][base + 6'(k)] = sb_out[k][1];
      nx[4][base + 6'(k)] = sb_out[k][0];
    end
    st_sub = {nx[0], nx[1], nx[2], nx[3], nx[4]};
  end

`ifdef SUB_LAYER_ADD_CONST_EN
  // constant lands in x2[7:0] before any column is touched
  always_comb begin
    st_ld = state_i;
    st_ld[135:128] = state_i[135:128] ^ {4'hF - round_i, round_i};
  end
`else
  assign st_ld = state_i;
`endif

  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    st_d  = st_q;
    unique case (fsm_q)
      RUN: begin
        st_d = st_sub;
        if (cnt_q == LAST) begin
          cnt_d = '0;
          fsm_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE, DONE: begin
        if (start_i) begin
          st_d  = st_ld;
          cnt_d = '0;
          fsm_d = RUN;
        end else begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q <= IDLE;
      cnt_q <= '0;
      st_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      st_q  <= st_d;
    end
  end

  assign state_o = st_q;
  assign busy_o  = (fsm_q == RUN);
  assign done_o  = (fsm_q == DONE);

endmodule

// File: tb/tb_sub_layer_seq.sv
// Bench for sub_layer_seq: NB_SBOX=1 and NB_SBOX=8 instances against
// a column-level reference model, plus directed literal scenarios.

`ifdef SUB_LAYER_ADD_CONST_EN
`define LD(s, d) ((s) ^ {184'b0, 4'hF - rnd[d], rnd[d], 128'b0})
`else
`define LD(s, d) (s)
`endif

module tb_sub_layer_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start [2];
  logic [319:0] sti   [2];
  logic [319:0] so    [2];
  logic         busy  [2];
  logic         done  [2];
`ifdef SUB_LAYER_ADD_CONST_EN
  logic [3:0]   rnd   [2];
`endif

  int vectors = 0;
  int errors  = 0;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  sub_layer_seq #(.NB_SBOX(1)) u_dut0 (
    .clock_i  (clk),
    .resetb_i (rst_n),
    .start_i  (start[0]),
    .state_i  (sti[0]),
`ifdef SUB_LAYER_ADD_CONST_EN
    .round_i  (rnd[0]),
`endif
    .state_o  (so[0]),
    .busy_o   (busy[0]),
    .done_o   (done[0])
  );

  sub_layer_seq #(.NB_SBOX(8)) u_dut1 (
    .clock_i  (clk),
    .resetb_i (rst_n),
    .start_i  (start[1]),
    .state_i  (sti[1]),
`ifdef SUB_LAYER_ADD_CONST_EN
    .round_i  (rnd[1]),
`endif
    .state_o  (so[1]),
    .busy_o   (busy[1]),
    .done_o   (done[1])
  );

  function automatic int nb(input int d);
    return (d == 0) ? 1 : 8;
  endfunction

  // substitute columns 0..ncols-1 of s via the S-box table
  function automatic logic [319:0] sub_cols(input logic [319:0] s,
                                            input int ncols);
    logic [319:0] r;
    logic [4:0] w, v;
    r = s;
    for (int j = 0; j < ncols; j++) begin
      w = {s[256+j], s[192+j], s[128+j], s[64+j], s[j]};
      v = SBOX[w];
      r[256+j] = v[4];
      r[192+j] = v[3];
      r[128+j] = v[2];
      r[64+j]  = v[1];
      r[j]     = v[0];
    end
    return r;
  endfunction

  function automatic logic [319:0] r320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [319:0] act,
                     input logic [319:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // reference: edges left in the operation, columns done, loaded value
  int           m_left [2] = '{0, 0};
  int           m_k    [2] = '{0, 0};
  bit           m_done [2] = '{1'b0, 1'b0};
  logic [319:0] m_ld   [2] = '{320'b0, 320'b0};

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_left[d] <= 0;
        m_k[d]    <= 0;
        m_done[d] <= 1'b0;
        m_ld[d]   <= '0;
      end else if (m_left[d] > 0) begin
        m_k[d]    <= m_k[d] + 1;
        m_left[d] <= m_left[d] - 1;
        m_done[d] <= (m_left[d] == 1);
      end else begin
        m_done[d] <= 1'b0;
        if (start[d]) begin
          m_ld[d]   <= `LD(sti[d], d);
          m_k[d]    <= 0;
          m_left[d] <= 64 / nb(d);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy%0d", d), 320'(busy[d]), 320'(m_left[d] > 0));
      chk($sformatf("done%0d", d), 320'(done[d]), 320'(m_done[d]));
      chk($sformatf("state%0d", d), so[d],
          sub_cols(m_ld[d], m_k[d] * nb(d)));
    end
  end

  task automatic wait_done(input int d, input int n0, output int n);
    n = n0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (done[d]) break;
    end
    chk("done_seen", 320'(done[d]), 320'(1));
  endtask

  task automatic run_op(input int d, input logic [319:0] s, output int n);
    start[d] = 1'b1;
    sti[d]   = s;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    wait_done(d, 0, n);
  endtask

  initial begin
    int n;
    bit seen;
    logic [319:0] a, b;
    start = '{1'b0, 1'b0};
    sti   = '{320'b0, 320'b0};
`ifdef SUB_LAYER_ADD_CONST_EN
    rnd   = '{4'd0, 4'd0};
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", so[0], 320'b0);
    chk("rst_busy", 320'(busy[0]), 320'(0));
    chk("rst_done", 320'(done[0]), 320'(0));
    rst_n = 1'b1;

`ifdef SUB_LAYER_ADD_CONST_EN
    rnd[0] = 4'd0;
    run_op(0, 320'b0, n);
    chk("lat_nb1", 320'(n), 320'(64));
    chk("const_zero", so[0], {64'h00000000000000F0, 64'h00000000000000F0,
                              64'hFFFFFFFFFFFFFF0F, 64'h00000000000000F0,
                              64'h0});
`else
    run_op(0, 320'b0, n);
    chk("lat_nb1", 320'(n), 320'(64));
    chk("zero_nb1", so[0], {64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF,
                            64'h0, 64'h0});
    run_op(1, {320{1'b1}}, n);
    chk("lat_nb8", 320'(n), 320'(8));
    chk("ones_nb8", so[1], {64'hFFFFFFFFFFFFFFFF, 64'h0,
                            64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                            64'hFFFFFFFFFFFFFFFF});
`endif

    // second start mid-run must be ignored
    a = r320();
    b = ~a;
    start[0] = 1'b1;
    sti[0]   = a;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    start[0] = 1'b1;
    sti[0]   = b;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    wait_done(0, 11, n);
    chk("ign_lat", 320'(n), 320'(64));
    chk("ign_res", so[0], sub_cols(`LD(a, 0), 64));

    // reset pulse mid-run
    start[0] = 1'b1;
    sti[0]   = r320();
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", so[0], 320'b0);
    chk("mid_rst_busy", 320'(busy[0]), 320'(0));
    chk("mid_rst_done", 320'(done[0]), 320'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk);
      #1;
      seen |= done[0];
    end
    chk("no_done_after_rst", 320'(seen), 320'(0));
    a = r320();
    run_op(0, a, n);
    chk("post_rst_lat", 320'(n), 320'(64));
    chk("post_rst_res", so[0], sub_cols(`LD(a, 0), 64));

    // start held high through DONE on the NB_SBOX=8 instance
    a = r320();
    b = r320();
    start[1] = 1'b1;
    sti[1]   = a;
    @(posedge clk);
    #1;
    wait_done(1, 0, n);
    chk("b2b_lat1", 320'(n), 320'(8));
    chk("b2b_res1", so[1], sub_cols(`LD(a, 1), 64));
    sti[1] = b;
    @(posedge clk);
    #1;
    chk("b2b_busy", 320'(busy[1]), 320'(1));
    chk("b2b_done_low", 320'(done[1]), 320'(0));
    start[1] = 1'b0;
    wait_done(1, 0, n);
    chk("b2b_lat2", 320'(n), 320'(8));
    chk("b2b_res2", so[1], sub_cols(`LD(b, 1), 64));

    // random traffic, checked every cycle by the compare process
    repeat (800) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        start[d] = ($urandom_range(0, 7) == 0);
        sti[d]   = r320();
`ifdef SUB_LAYER_ADD_CONST_EN
        rnd[d]   = 4'($urandom_range(0, 15));
`endif
      end
    end
    start = '{1'b0, 1'b0};
    repeat (80) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
